control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 87 ++++++++
 rtl/control_unit_if.sv | 33 +++
 rtl/control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_control_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared CPU definitions: FSM state encoding, opcode constants,
// the control-word layout and the opcode classification helper.
package control_unit_pkg;

    // Control-sequencer states; each non-terminal state lasts one clock
    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH0 = 4'd1,
        S_FETCH1 = 4'd2,
        S_FETCH2 = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_T7     = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    // Raw 5-bit opcode values as they appear in the instruction word
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10011;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // Instruction classes the sequencer distinguishes; unknown codes are nop
    typedef enum logic [3:0] {
        OP_LD,
        OP_ST,
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_BR,
        OP_JR,
        OP_NOP,
        OP_HALT
    } op_t;

    // One bit per datapath control line, grouped by function
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic c_out;
        logic ba_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic con_in;
        logic r_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_out;
        logic inc_pc;
        logic read;
        logic write;
        logic add;
        logic sub;
    } ctrl_t;

    // Maps a raw opcode onto its instruction class, folding unknowns into nop
    function automatic op_t decode_op(input logic [4:0] opc);
        op_t op;
        case (opc)
            OPC_LD:   op = OP_LD;
            OPC_ST:   op = OP_ST;
            OPC_ADD:  op = OP_ADD;
            OPC_SUB:  op = OP_SUB;
            OPC_ADDI: op = OP_ADDI;
            OPC_BR:   op = OP_BR;
            OPC_JR:   op = OP_JR;
            OPC_HALT: op = OP_HALT;
            default:  op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle of instruction/status inputs and datapath control outputs
// between the control unit (master) and the datapath (slave).
interface control_unit_if;

    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;

    logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, CONin, Rin;
    logic Gra, Grb, Grc, Rout;
    logic IncPC, Read, Write, ADD, SUB;
    logic Run;

    modport master (
        input  IR, CON_FF, Stop,
        output PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, CONin, Rin,
        output Gra, Grb, Grc, Rout,
        output IncPC, Read, Write, ADD, SUB,
        output Run
    );

    modport slave (
        output IR, CON_FF, Stop,
        input  PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, CONin, Rin,
        input  Gra, Grb, Grc, Rout,
        input  IncPC, Read, Write, ADD, SUB,
        input  Run
    );

endinterface

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch, then T3..T7 per instruction class,
// with combinational control outputs decoded from state, opcode and CON_FF.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int OPC_HI = 31
) (
    input  logic          Clock,
    input  logic          Reset,
    control_unit_if.master bus
);

    state_t state;
    state_t next_state;
    op_t    op;
    ctrl_t  ctrl;

    assign op = decode_op(bus.IR[OPC_HI -: 5]);

    // State register; Reset forces RESET at once, even mid-instruction
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= S_RESET;
        else
            state <= next_state;
    end

    // Next-state and control-word decode; every line defaults to inactive
    always_comb begin
        ctrl       = '0;
        next_state = state;
        case (state)
            S_RESET: begin
                next_state = S_FETCH0;
            end
            S_FETCH0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
                next_state  = bus.Stop ? S_HALTED : S_FETCH1;
            end
            S_FETCH1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
                next_state    = S_FETCH2;
            end
            S_FETCH2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                next_state   = S_T3;
            end
            S_T3: begin
                case (op)
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                        next_state = S_T4;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                        next_state  = S_T4;
                    end
                    OP_BR: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.con_in = 1'b1;
                        next_state  = S_T4;
                    end
                    OP_JR: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.pc_in = 1'b1;
                        next_state = S_FETCH0;
                    end
                    OP_HALT: begin
                        next_state = S_HALTED;
                    end
                    default: begin
                        next_state = S_FETCH0;
                    end
                endcase
            end
            S_T4: begin
                next_state = S_T5;
                case (op)
                    OP_ADD, OP_SUB: begin
                        ctrl.grc   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.z_in  = 1'b1;
                        ctrl.add   = (op == OP_ADD);
                        ctrl.sub   = (op == OP_SUB);
                    end
                    OP_ADDI, OP_LD, OP_ST: begin
                        ctrl.c_out = 1'b1;
                        ctrl.add   = 1'b1;
                        ctrl.z_in  = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    default: begin
                        next_state = S_FETCH0;
                    end
                endcase
            end
            S_T5: begin
                case (op)
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                        next_state    = S_FETCH0;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                        next_state    = S_T6;
                    end
                    OP_BR: begin
                        ctrl.c_out = 1'b1;
                        ctrl.add   = 1'b1;
                        ctrl.z_in  = 1'b1;
                        next_state = S_T6;
                    end
                    default: begin
                        next_state = S_FETCH0;
                    end
                endcase
            end
            S_T6: begin
                case (op)
                    OP_LD: begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                        next_state  = S_T7;
                    end
                    OP_ST: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                        next_state  = S_T7;
                    end
                    OP_BR: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.pc_in    = bus.CON_FF;
                        next_state    = S_FETCH0;
                    end
                    default: begin
                        next_state = S_FETCH0;
                    end
                endcase
            end
            S_T7: begin
                next_state = S_FETCH0;
                case (op)
                    OP_LD: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    OP_ST: begin
                        ctrl.write = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_HALTED: begin
                next_state = S_HALTED;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    assign bus.PCout    = ctrl.pc_out;
    assign bus.Zlowout  = ctrl.zlow_out;
    assign bus.Zhighout = ctrl.zhigh_out;
    assign bus.MDRout   = ctrl.mdr_out;
    assign bus.Cout     = ctrl.c_out;
    assign bus.BAout    = ctrl.ba_out;
    assign bus.MARin    = ctrl.mar_in;
    assign bus.Zin      = ctrl.z_in;
    assign bus.PCin     = ctrl.pc_in;
    assign bus.MDRin    = ctrl.mdr_in;
    assign bus.IRin     = ctrl.ir_in;
    assign bus.Yin      = ctrl.y_in;
    assign bus.CONin    = ctrl.con_in;
    assign bus.Rin      = ctrl.r_in;
    assign bus.Gra      = ctrl.gra;
    assign bus.Grb      = ctrl.grb;
    assign bus.Grc      = ctrl.grc;
    assign bus.Rout     = ctrl.r_out;
    assign bus.IncPC    = ctrl.inc_pc;
    assign bus.Read     = ctrl.read;
    assign bus.Write    = ctrl.write;
    assign bus.ADD      = ctrl.add;
    assign bus.SUB      = ctrl.sub;

    assign bus.Run = (state != S_RESET) && (state != S_HALTED);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios followed by random
// instruction streams, checked cycle by cycle against a per-instruction
// list of expected control words.
module tb_control_unit;

    logic Clock;
    logic Reset;

    control_unit_if bus ();

    control_unit #(.OPC_HI(31)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    localparam logic [22:0] M_PCOUT  = 23'd1 << 22;
    localparam logic [22:0] M_ZLOW   = 23'd1 << 21;
    localparam logic [22:0] M_ZHIGH  = 23'd1 << 20;
    localparam logic [22:0] M_MDROUT = 23'd1 << 19;
    localparam logic [22:0] M_COUT   = 23'd1 << 18;
    localparam logic [22:0] M_BAOUT  = 23'd1 << 17;
    localparam logic [22:0] M_MARIN  = 23'd1 << 16;
    localparam logic [22:0] M_ZIN    = 23'd1 << 15;
    localparam logic [22:0] M_PCIN   = 23'd1 << 14;
    localparam logic [22:0] M_MDRIN  = 23'd1 << 13;
    localparam logic [22:0] M_IRIN   = 23'd1 << 12;
    localparam logic [22:0] M_YIN    = 23'd1 << 11;
    localparam logic [22:0] M_CONIN  = 23'd1 << 10;
    localparam logic [22:0] M_RIN    = 23'd1 << 9;
    localparam logic [22:0] M_GRA    = 23'd1 << 8;
    localparam logic [22:0] M_GRB    = 23'd1 << 7;
    localparam logic [22:0] M_GRC    = 23'd1 << 6;
    localparam logic [22:0] M_ROUT   = 23'd1 << 5;
    localparam logic [22:0] M_INCPC  = 23'd1 << 4;
    localparam logic [22:0] M_READ   = 23'd1 << 3;
    localparam logic [22:0] M_WRITE  = 23'd1 << 2;
    localparam logic [22:0] M_ADD    = 23'd1 << 1;
    localparam logic [22:0] M_SUB    = 23'd1 << 0;

    localparam logic [22:0] W_FETCH0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [22:0] W_FETCH1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [22:0] W_FETCH2 = M_MDROUT | M_IRIN;

    wire [22:0] obsWord = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout,
                           bus.Cout, bus.BAout, bus.MARin, bus.Zin, bus.PCin,
                           bus.MDRin, bus.IRin, bus.Yin, bus.CONin, bus.Rin,
                           bus.Gra, bus.Grb, bus.Grc, bus.Rout, bus.IncPC,
                           bus.Read, bus.Write, bus.ADD, bus.SUB};

    int compared   = 0;
    int mismatched = 0;

    logic [22:0] expQ[$];
    bit          expHalts;
    bit          inHalt;

    logic [4:0] knownOps [9] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100,
                                 5'b01100, 5'b10010, 5'b10011, 5'b11010,
                                 5'b11011};

    // Free-running clock, 10 time units per period
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: the control words after FETCH0 for one instruction
    task automatic buildExpected(input logic [4:0] opc, input logic con);
        expQ     = {};
        expHalts = 1'b0;
        expQ.push_back(W_FETCH1);
        expQ.push_back(W_FETCH2);
        case (opc)
            5'b00011, 5'b00100: begin
                expQ.push_back(M_GRB | M_ROUT | M_YIN);
                expQ.push_back(M_GRC | M_ROUT | M_ZIN | ((opc == 5'b00011) ? M_ADD : M_SUB));
                expQ.push_back(M_ZLOW | M_GRA | M_RIN);
            end
            5'b01100: begin
                expQ.push_back(M_GRB | M_ROUT | M_YIN);
                expQ.push_back(M_COUT | M_ADD | M_ZIN);
                expQ.push_back(M_ZLOW | M_GRA | M_RIN);
            end
            5'b00000, 5'b00010: begin
                expQ.push_back(M_GRB | M_BAOUT | M_YIN);
                expQ.push_back(M_COUT | M_ADD | M_ZIN);
                expQ.push_back(M_ZLOW | M_MARIN);
                if (opc == 5'b00000) begin
                    expQ.push_back(M_READ | M_MDRIN);
                    expQ.push_back(M_MDROUT | M_GRA | M_RIN);
                end else begin
                    expQ.push_back(M_GRA | M_ROUT | M_MDRIN);
                    expQ.push_back(M_WRITE);
                end
            end
            5'b10010: begin
                expQ.push_back(M_GRA | M_ROUT | M_CONIN);
                expQ.push_back(M_PCOUT | M_YIN);
                expQ.push_back(M_COUT | M_ADD | M_ZIN);
                expQ.push_back(M_ZLOW | (con ? M_PCIN : 23'd0));
            end
            5'b10011: begin
                expQ.push_back(M_GRA | M_ROUT | M_PCIN);
            end
            5'b11011: begin
                expQ.push_back(23'd0);
                expHalts = 1'b1;
            end
            default: begin
                expQ.push_back(23'd0);
            end
        endcase
    endtask

    // Compares the full control word plus Run, and the bus-safety invariants
    task automatic checkOutput(input string tag, input logic [22:0] expWord, input logic expRun);
        logic [23:0] obs;
        logic [23:0] exp;
        logic [1:0]  clash;
        obs   = {bus.Run, obsWord};
        exp   = {expRun, expWord};
        clash = {bus.Read & bus.Write, bus.PCin & bus.PCout};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed run+word=%h expected %h", tag, obs, exp);
        end
        compared++;
        assert (clash === 2'b00) else begin
            mismatched++;
            $error("[TB] FAIL %s_clash: observed rdwr/pcinout=%b expected 00", tag, clash);
        end
    endtask

    // Asserts Reset mid-cycle, checks the idle outputs, then releases it
    task automatic doReset(input string tag);
        @(negedge Clock);
        #1 Reset = 1'b1;
        #1 checkOutput({tag, "_during"}, 23'd0, 1'b0);
        @(posedge Clock);
        #1 checkOutput({tag, "_held"}, 23'd0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        Bus_stop_clear();
        @(posedge Clock);
        #1 checkOutput({tag, "_fetch0"}, W_FETCH0, 1'b1);
        inHalt = 1'b0;
    endtask

    task automatic Bus_stop_clear();
        bus.Stop = 1'b0;
    endtask

    // Runs one instruction from FETCH0; stopInFetch halts instead of fetching
    task automatic applyStimulus(input logic [4:0] opc, input logic con,
                                 input bit stopInFetch, input bit stopLater,
                                 input string tag);
        logic [26:0] fields;
        fields     = 27'($urandom);
        bus.IR     = {opc, fields};
        bus.CON_FF = con;
        bus.Stop   = stopInFetch;
        if (stopInFetch) begin
            @(posedge Clock);
            #1 bus.Stop = 1'b0;
            checkOutput({tag, "_stop_halted"}, 23'd0, 1'b0);
            inHalt = 1'b1;
            return;
        end
        buildExpected(opc, con);
        foreach (expQ[i]) begin
            @(posedge Clock);
            #1 checkOutput($sformatf("%s_c%0d", tag, i + 1), expQ[i], 1'b1);
            bus.Stop = stopLater;
        end
        @(posedge Clock);
        #1 bus.Stop = 1'b0;
        if (expHalts) begin
            checkOutput({tag, "_halted"}, 23'd0, 1'b0);
            inHalt = 1'b1;
        end else begin
            checkOutput({tag, "_next_fetch0"}, W_FETCH0, 1'b1);
        end
    endtask

    initial begin
        logic [4:0] opc;
        Reset      = 1'b0;
        bus.IR     = 32'h0;
        bus.CON_FF = 1'b0;
        bus.Stop   = 1'b0;
        inHalt     = 1'b0;

        #1 Reset = 1'b1;
        #1 checkOutput("reset_idle", 23'd0, 1'b0);
        @(posedge Clock);
        #1 checkOutput("reset_held", 23'd0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1 checkOutput("first_fetch0", W_FETCH0, 1'b1);

        $display("[TB] directed add R1,R2,R3");
        bus.IR     = 32'h18918000;
        bus.CON_FF = 1'b0;
        buildExpected(5'b00011, 1'b0);
        foreach (expQ[i]) begin
            @(posedge Clock);
            #1 checkOutput($sformatf("add_fixed_c%0d", i + 1), expQ[i], 1'b1);
        end
        @(posedge Clock);
        #1 checkOutput("add_fixed_fetch0", W_FETCH0, 1'b1);

        $display("[TB] directed branch, ld/st, stop handling");
        applyStimulus(5'b10010, 1'b1, 1'b0, 1'b0, "br_taken");
        applyStimulus(5'b10010, 1'b0, 1'b0, 1'b0, "br_nottaken");
        applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0, "ld");
        applyStimulus(5'b00010, 1'b0, 1'b0, 1'b0, "st");
        applyStimulus(5'b00011, 1'b0, 1'b0, 1'b1, "add_stop_late");
        applyStimulus(5'b11010, 1'b0, 1'b1, 1'b0, "stop_fetch");
        repeat (3) begin
            @(posedge Clock);
            #1 checkOutput("stop_stays_halted", 23'd0, 1'b0);
        end
        doReset("rst_after_stop");

        $display("[TB] directed halt opcode");
        applyStimulus(5'b11011, 1'b0, 1'b0, 1'b0, "halt");
        repeat (3) begin
            bus.Stop = 1'($urandom);
            @(posedge Clock);
            #1 checkOutput("halt_stays", 23'd0, 1'b0);
        end
        doReset("rst_after_halt");

        $display("[TB] directed reset during ld T5");
        bus.IR = {5'b00000, 27'h0123456};
        buildExpected(5'b00000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1 checkOutput($sformatf("ld_abort_c%0d", i + 1), expQ[i], 1'b1);
        end
        #3 Reset = 1'b1;
        #1 checkOutput("ld_abort_reset", 23'd0, 1'b0);
        #1 Reset = 1'b0;
        @(posedge Clock);
        #1 checkOutput("ld_abort_fetch0", W_FETCH0, 1'b1);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0)
                opc = knownOps[$urandom_range(0, 8)];
            else
                opc = 5'($urandom);
            applyStimulus(opc, 1'($urandom), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 2) == 0), $sformatf("rnd%0d_op%b", n, opc));
            if (inHalt)
                doReset($sformatf("rnd%0d_rst", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
